// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
// Instruction fetch front end. It keeps one fetch in flight to a synchronous
// instruction memory and buffers the returned words in a 2-entry skid FIFO
// ahead of decode. It also handles branch/jump redirects and latches a sticky
// fault on a misaligned redirect or a fetch past the end of the ROM.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : synchronous active-high reset
//   imem_addr      : fetch byte address to instruction memory (read_add)
//   imem_rdata     : instruction memory data, valid one cycle after imem_addr
//   redirect_valid : redirect strobe from branch/jump resolution
//   redirect_pc    : redirect target byte address
//   inst_valid     : FIFO head holds an instruction for decode
//   inst_ready     : decode accepts the head instruction
//   inst_data      : head instruction word
//   inst_pc        : byte address of inst_data
//   fetch_fault    : sticky fault, cleared only by rst
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam logic [0:0]  ST_RUN   = 1'b0;
    localparam logic [0:0]  ST_FAULT = 1'b1;
    localparam logic [31:0] LAST_PC  = 32'(4 * ROM_WORDS - 4);

    logic [0:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_fifo_pc   [2];
    logic [31:0] r_fifo_data [2];
    logic        r_head;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic        w_redirect;
    logic        w_fault_enter;
    logic        w_wr_idx;
    logic [2:0]  w_occupancy;

    // Outputs: the memory address follows fetch_pc, the decode side shows the FIFO head.
    // Both are forced to their reset values while rst is high so that nothing stale
    // leaks out before the reset edge lands.
    always_comb begin
        if (rst) begin
            imem_addr  = RESET_PC;
            inst_valid = 1'b0;
            inst_data  = 32'h0000_0000;
            inst_pc    = 32'h0000_0000;
        end else begin
            imem_addr  = r_fetch_pc;
            inst_valid = (r_count != 2'd0);
            inst_data  = r_fifo_data[r_head];
            inst_pc    = r_fifo_pc[r_head];
        end
        fetch_fault = (r_state == ST_FAULT);
    end

    // Slots that will be occupied after this edge if nothing new is issued: entries
    // already buffered plus the word returning now, minus the one decode takes.
    // A pop implies r_count >= 1, so this never underflows.
    assign w_pop       = inst_valid & inst_ready;
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Next-action decode: redirect beats issue; bad targets or fetch addresses fault.
    always_comb begin
        w_issue       = 1'b0;
        w_redirect    = 1'b0;
        w_fault_enter = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (redirect_valid) begin
                    if (redirect_pc[1:0] != 2'b00) begin
                        w_fault_enter = 1'b1;
                    end else begin
                        w_redirect = 1'b1;
                    end
                end else if (w_occupancy < 3'd2) begin
                    // No wrap: running off the ROM end is a fault, not a fetch of 0.
                    if ((r_fetch_pc > LAST_PC) || (r_fetch_pc[1:0] != 2'b00)) begin
                        w_fault_enter = 1'b1;
                    end else begin
                        w_issue = 1'b1;
                    end
                end else begin
                    w_issue = 1'b0;
                end
            end
            ST_FAULT: begin
                w_issue = 1'b0;
            end
            default: begin
                w_fault_enter = 1'b1;
            end
        endcase
    end

    // A returning word is dropped only by a redirect; in FAULT it is still delivered.
    assign w_push = r_inflight & ~w_redirect;

    // Tail slot: with 0 or 2 entries the tail aliases the head (with 2 entries
    // that slot is only written when the head is popped in the same cycle).
    assign w_wr_idx = r_head ^ r_count[0];

    // Control state: FSM, fetch pointer and the single in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else begin
            if (w_fault_enter) begin
                r_state <= ST_FAULT;
            end else begin
                r_state <= r_state;
            end
            if (w_redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end else begin
                r_fetch_pc <= r_fetch_pc;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
            end else begin
                r_inflight_pc <= r_inflight_pc;
            end
        end
    end

    // Skid FIFO storage and pointers; a redirect flushes it, consuming any same-cycle pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_pc[i]   <= 32'h0000_0000;
                r_fifo_data[i] <= 32'h0000_0000;
            end
        end else if (w_redirect) begin
            r_head  <= r_head;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_pc[w_wr_idx]   <= r_inflight_pc;
                r_fifo_data[w_wr_idx] <= imem_rdata;
            end else begin
                r_fifo_pc[w_wr_idx]   <= r_fifo_pc[w_wr_idx];
                r_fifo_data[w_wr_idx] <= r_fifo_data[w_wr_idx];
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end else begin
                r_head <= r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Testbench for instr_fetch_ctrl: a synchronous ROM model (word k = A000_0000 + k),
// directed stimulus that queues the expected {pc, data} deliveries, and a monitor
// that checks every handshake against that queue.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    instr_fetch_ctrl #(.RESET_PC(RESET_PC), .ROM_WORDS(512)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data for the address presented in a cycle appears the next cycle.
    always @(posedge clk) begin
        imem_rdata <= 32'hA000_0000 + {2'b00, imem_addr[31:2]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] pc, input logic [31:0] data);
        exp_q.push_back({pc, data});
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every accepted instruction must be the next expected one.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop_pc", inst_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", inst_pc, e[63:32]);
                    check("sb_data", inst_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        tick();
        tick();
        tick();
        // Reset state
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);

        // Streaming with inst_ready held high
        rst        = 1'b0;
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            expect_word(32'(k * 4), 32'hA000_0000 + 32'(k));
        end
        tick();
        check("stream_valid_c1", {31'd0, inst_valid}, 32'd0);
        tick();
        check("stream_first_valid_c2", {31'd0, inst_valid}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("stream_no_gap", {31'd0, inst_valid}, 32'd1);
            tick();
        end
        inst_ready = 1'b0;

        // Backpressure: hold the head for 5 cycles, then release for 3 pops
        do_reset();
        tick();
        tick();
        check("bp_first_valid", {31'd0, inst_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", {31'd0, inst_valid}, 32'd1);
            check("bp_hold_pc", inst_pc, 32'h0000_0000);
            check("bp_hold_data", inst_data, 32'hA000_0000);
        end
        expect_word(32'h0000_0000, 32'hA000_0000);
        expect_word(32'h0000_0004, 32'hA000_0001);
        expect_word(32'h0000_0008, 32'hA000_0002);
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_release_valid", {31'd0, inst_valid}, 32'd1);
            tick();
        end
        inst_ready = 1'b0;

        // Redirect while the FIFO is full
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("redir_c1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("redir_c2_valid", {31'd0, inst_valid}, 32'd1);
        check("redir_c2_pc", inst_pc, 32'h0000_0100);
        check("redir_c2_data", inst_data, 32'hA000_0040);
        expect_word(32'h0000_0100, 32'hA000_0040);
        expect_word(32'h0000_0104, 32'hA000_0041);
        inst_ready = 1'b1;
        tick();
        tick();
        inst_ready = 1'b0;

        // Misaligned redirect: fault, buffered and in-flight words still drain
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        check("mis_fault_set", {31'd0, fetch_fault}, 32'd1);
        check("mis_head_pc", inst_pc, 32'h0000_0108);
        expect_word(32'h0000_0108, 32'hA000_0042);
        expect_word(32'h0000_010C, 32'hA000_0043);
        inst_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            check("mis_drained_valid", {31'd0, inst_valid}, 32'd0);
            check("mis_fault_sticky", {31'd0, fetch_fault}, 32'd1);
            tick();
            redirect_valid = 1'b0;
        end
        inst_ready = 1'b0;
        do_reset();
        check("mis_rst_clears_fault", {31'd0, fetch_fault}, 32'd0);

        // Range end: 0x7F8 and 0x7FC delivered, then fault with no 0x800
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_07F8;
        expect_word(32'h0000_07F8, 32'hA000_01FE);
        expect_word(32'h0000_07FC, 32'hA000_01FF);
        inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("range_fault", {31'd0, fetch_fault}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("range_no_more_valid", {31'd0, inst_valid}, 32'd0);
            tick();
        end
        inst_ready = 1'b0;

        // Reset mid-stream with a word in flight and one buffered
        do_reset();
        tick();
        tick();
        check("midrst_pre_valid", {31'd0, inst_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_during_addr", imem_addr, RESET_PC);
        check("midrst_during_pc", inst_pc, 32'd0);
        check("midrst_during_data", inst_data, 32'd0);
        tick();
        rst = 1'b0;
        check("midrst_after_valid", {31'd0, inst_valid}, 32'd0);
        check("midrst_after_addr", imem_addr, RESET_PC);
        expect_word(32'h0000_0000, 32'hA000_0000);
        expect_word(32'h0000_0004, 32'hA000_0001);
        inst_ready = 1'b1;
        tick();
        check("midrst_c1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("midrst_c2_pc", inst_pc, 32'h0000_0000);
        tick();
        tick();
        inst_ready = 1'b0;
        tick();

        check("sb_all_consumed", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
